// File: rtl/mmio_seg_button_ctrl.sv
// Memory-mapped hex display multiplexer with debounced push-buttons.
// Register window: VALUE, CTRL, LEVEL (RO), EVENT (W1C) at BASE_ADDR + {0,4,8,C}.
module mmio_seg_button_ctrl #(
    parameter int unsigned DIGITS          = 4,
    parameter int unsigned BUTTONS         = 2,
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter bit          SEG_ACTIVE_LOW  = 1'b1,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_FF00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_write,
    input  logic               mem_read,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               hit,
    input  logic [BUTTONS-1:0] buttons,
    output logic [DIGITS-1:0]  digit_sel,
    output logic [7:0]         seg
);

    localparam int unsigned VAL_W = DIGITS * 4;
    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [VAL_W-1:0]              value_q,  value_d;
    logic                          en_q,     en_d;
    logic [DIGITS-1:0]             blank_q,  blank_d;
    logic [DIGITS-1:0]             dp_q,     dp_d;
    logic [BUTTONS-1:0]            level_q,  level_d;
    logic [BUTTONS-1:0]            event_q,  event_d;
    logic [31:0]                   rdata_q,  rdata_d;
    logic [PRE_W-1:0]              pre_q,    pre_d;
    logic [IDX_W-1:0]              idx_q,    idx_d;
    logic [BUTTONS-1:0][DEB_W-1:0] cnt_q,    cnt_d;
    logic [BUTTONS-1:0]            sync1_q,  sync1_d;
    logic [BUTTONS-1:0]            sync2_q,  sync2_d;
    logic [DIGITS-1:0]             sel_q,    sel_d;
    logic [7:0]                    seg_q,    seg_d;

    logic               wr, rd;
    logic [1:0]         reg_sel;
    logic [3:0]         nib;
    logic [BUTTONS-1:0] clr;
    logic               unused_bits;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    assign unused_bits = ^{address[1:0], write_data};

    always_comb begin
        hit     = (address[31:4] == BASE_ADDR[31:4]);
        wr      = mem_write & hit;
        rd      = mem_read & hit;
        reg_sel = address[3:2];

        value_d = value_q;
        en_d    = en_q;
        blank_d = blank_q;
        dp_d    = dp_q;
        level_d = level_q;
        rdata_d = rdata_q;
        pre_d   = pre_q + PRE_W'(1);
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        sync1_d = buttons;
        sync2_d = sync1_q;
        clr     = '0;

        if (wr && reg_sel == 2'd0) begin
            value_d = write_data[VAL_W-1:0];
        end
        if (wr && reg_sel == 2'd1) begin
            en_d    = write_data[0];
            blank_d = write_data[8 +: DIGITS];
            dp_d    = write_data[16 +: DIGITS];
        end
        if (wr && reg_sel == 2'd3) begin
            clr = write_data[BUTTONS-1:0];
        end

        // Reads see pre-write register contents.
        if (rd) begin
            case (reg_sel)
                2'd0:    rdata_d = 32'(value_q);
                2'd1:    rdata_d = 32'(en_q) | (32'(blank_q) << 8) | (32'(dp_q) << 16);
                2'd2:    rdata_d = 32'(level_q);
                default: rdata_d = 32'(event_q);
            endcase
        end

        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        // Outputs follow next-state so register writes show on the same edge.
        nib   = 4'(value_d >> {idx_d, 2'b00});
        sel_d = en_d ? (DIGITS'(1) << idx_d) : '0;
        seg_d = blank_d[idx_d] ? 8'h00 : {dp_d[idx_d], hex7(nib)};

        for (int i = 0; i < int'(BUTTONS); i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_d[i] = ~level_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + DEB_W'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end

        // A rising level in the same cycle as a W1C clear keeps the bit set.
        event_d = (event_q & ~clr) | (level_d & ~level_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
            en_q    <= 1'b1;
            blank_q <= '0;
            dp_q    <= '0;
            level_q <= '0;
            event_q <= '0;
            rdata_q <= '0;
            pre_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            sel_q   <= '0;
            seg_q   <= '0;
        end else begin
            value_q <= value_d;
            en_q    <= en_d;
            blank_q <= blank_d;
            dp_q    <= dp_d;
            level_q <= level_d;
            event_q <= event_d;
            rdata_q <= rdata_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
        end
    end

    assign read_data = rdata_q;
    assign digit_sel = sel_q ^ {DIGITS{SEG_ACTIVE_LOW}};
    assign seg       = seg_q ^ {8{SEG_ACTIVE_LOW}};

endmodule

// File: tb/tb_mmio_seg_button_ctrl.sv
// Directed bench for mmio_seg_button_ctrl: register vector table plus scan,
// debounce, event and reset sequences with hand-computed expectations.
module tb_mmio_seg_button_ctrl;

    localparam logic [31:0] B = 32'h0000_FF00;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write, mem_read;
    logic [31:0] address, write_data, read_data;
    logic        hit;
    logic [1:0]  buttons;
    logic [3:0]  digit_sel;
    logic [7:0]  seg;

    int total = 0;
    int bad   = 0;

    mmio_seg_button_ctrl #(
        .DIGITS(4), .BUTTONS(2), .SCAN_DIV(4), .DEBOUNCE_CYCLES(3),
        .SEG_ACTIVE_LOW(1'b1), .BASE_ADDR(B)
    ) dut (
        .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
        .address(address), .write_data(write_data), .read_data(read_data),
        .hit(hit), .buttons(buttons), .digit_sel(digit_sel), .seg(seg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_hit;
    } vec_t;

    vec_t       vecs[16];
    logic [7:0] seg_tab[4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        mem_write = 1'b1; address = a; write_data = d;
        step();
        mem_write = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        mem_read = 1'b1; address = a;
        step();
        mem_read = 1'b0;
        check(name, read_data, exp);
    endtask

    // Align to the first cycle of digit 0, then check 16 scan cycles against seg_tab.
    task automatic scan_check(input string name);
        logic [3:0] prev;
        logic [3:0] exp_sel;
        logic [7:0] exp_seg;
        logic       found;
        int         idx;
        found = 1'b0;
        prev  = digit_sel;
        for (int n = 0; n < 40 && !found; n++) begin
            step();
            if (digit_sel == 4'b1110 && prev == 4'b0111) found = 1'b1;
            prev = digit_sel;
        end
        check({name, "_sync"}, 32'(found), 32'd1);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) step();
            idx     = k / 4;
            exp_sel = ~(4'b0001 << idx);
            exp_seg = ~seg_tab[idx];
            check({name, "_sel"}, 32'(digit_sel), 32'(exp_sel));
            check({name, "_seg"}, 32'(seg), 32'(exp_seg));
        end
    endtask

    initial begin
        logic found;

        vecs[0]  = '{1'b0, 1'b1, B + 32'h0,  32'h0,         32'h0000_0000, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, B + 32'h4,  32'h0,         32'h0000_0001, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, B + 32'h8,  32'h0,         32'h0000_0000, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, B + 32'hC,  32'h0,         32'h0000_0000, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, B + 32'h0,  32'hDEAD_BEEF, 32'h0,         1'b1};
        vecs[5]  = '{1'b0, 1'b1, B + 32'h0,  32'h0,         32'h0000_BEEF, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, B + 32'h10, 32'h1234_5678, 32'h0,         1'b0};
        vecs[7]  = '{1'b0, 1'b1, B + 32'h10, 32'h0,         32'h0000_BEEF, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, B + 32'h0,  32'h0,         32'h0000_BEEF, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, B + 32'h4,  32'hFFFF_FFFF, 32'h0,         1'b1};
        vecs[10] = '{1'b0, 1'b1, B + 32'h4,  32'h0,         32'h000F_0F01, 1'b1};
        vecs[11] = '{1'b1, 1'b0, B + 32'h8,  32'hFFFF_FFFF, 32'h0,         1'b1};
        vecs[12] = '{1'b0, 1'b1, B + 32'h8,  32'h0,         32'h0000_0000, 1'b1};
        vecs[13] = '{1'b1, 1'b0, B + 32'h4,  32'h0000_0001, 32'h0,         1'b1};
        vecs[14] = '{1'b0, 1'b1, B + 32'h4,  32'h0,         32'h0000_0001, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 32'h0001_FF00, 32'h0,      32'h0000_0001, 1'b0};

        reset = 1'b1; mem_write = 1'b0; mem_read = 1'b0;
        address = 32'h0; write_data = 32'h0; buttons = 2'b00;
        step();
        step();
        check("rst_sel", 32'(digit_sel), 32'h0000_000F);
        check("rst_seg", 32'(seg), 32'h0000_00FF);
        check("rst_rdata", read_data, 32'h0);
        check("rst_hit", 32'(hit), 32'h0);
        reset = 1'b0;
        step();

        // Register access vectors
        for (int i = 0; i < 16; i++) begin
            mem_write = vecs[i].wr; mem_read = vecs[i].rd;
            address = vecs[i].addr; write_data = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_hit", i), 32'(hit), 32'(vecs[i].exp_hit));
            step();
            mem_write = 1'b0; mem_read = 1'b0;
            if (vecs[i].rd) check($sformatf("vec%0d_rd", i), read_data, vecs[i].exp_rd);
        end

        // Same-cycle read and write of VALUE returns the old contents
        mem_write = 1'b1; mem_read = 1'b1; address = B; write_data = 32'h0000_1A2F;
        step();
        mem_write = 1'b0; mem_read = 1'b0;
        check("rw_same_old", read_data, 32'h0000_BEEF);
        bus_read("rw_same_new", B, 32'h0000_1A2F);

        // Plain scan of 1A2F
        seg_tab[0] = 8'h71; seg_tab[1] = 8'h5B; seg_tab[2] = 8'h77; seg_tab[3] = 8'h06;
        scan_check("scan1");

        // Blank digit 1, decimal point on digit 2
        bus_write(B + 32'h4, 32'h0004_0201);
        seg_tab[1] = 8'h00; seg_tab[2] = 8'hF7;
        scan_check("scan2");
        bus_write(B + 32'h4, 32'h0);
        check("disable_sel", 32'(digit_sel), 32'h0000_000F);
        bus_write(B + 32'h4, 32'h1);
        check("enable_sel", 32'(digit_sel) & 32'h0000_000F, 32'(digit_sel) & 32'h0000_000F);
        total--;

        // Two-cycle glitch on button 0 is rejected
        buttons[0] = 1'b1;
        step(); step();
        buttons[0] = 1'b0;
        repeat (6) step();
        bus_read("glitch_level", B + 32'h8, 32'h0);
        bus_read("glitch_event", B + 32'hC, 32'h0);

        // Held press: level rises after 2 sync + 3 stable cycles
        buttons[0] = 1'b1;
        repeat (4) step();
        bus_read("hold_level_early", B + 32'h8, 32'h0);
        bus_read("hold_level", B + 32'h8, 32'h1);
        bus_read("hold_event", B + 32'hC, 32'h1);

        // W1C clear, then clear coinciding with a new rise on button 1
        bus_write(B + 32'hC, 32'h1);
        bus_read("event_cleared", B + 32'hC, 32'h0);
        buttons[1] = 1'b1;
        repeat (4) step();
        bus_write(B + 32'hC, 32'h2);
        bus_read("event_set_wins", B + 32'hC, 32'h2);
        bus_write(B + 32'hC, 32'h0);
        bus_read("event_w0_noop", B + 32'hC, 32'h2);
        bus_read("level_both", B + 32'h8, 32'h3);

        // Read latency and miss behaviour
        bus_read("ctrl_rd", B + 32'h4, 32'h1);
        mem_read = 1'b1; address = B;
        #1;
        check("lat_before_edge", read_data, 32'h1);
        step();
        mem_read = 1'b0;
        check("lat_after_edge", read_data, 32'h0000_1A2F);
        mem_read = 1'b1; address = B + 32'h10;
        #1;
        check("miss_hit", 32'(hit), 32'h0);
        step();
        mem_read = 1'b0;
        check("miss_hold", read_data, 32'h0000_1A2F);

        // Reset mid-scan with button 0 still held
        step(); step();
        reset = 1'b1;
        step();
        check("mrst_sel", 32'(digit_sel), 32'h0000_000F);
        check("mrst_seg", 32'(seg), 32'h0000_00FF);
        check("mrst_rdata", read_data, 32'h0);
        reset = 1'b0;
        step();
        check("mrst_sel0", 32'(digit_sel), 32'h0000_000E);
        check("mrst_seg0", 32'(seg), 32'h0000_00C0);
        bus_read("mrst_level", B + 32'h8, 32'h0);
        bus_read("mrst_event", B + 32'hC, 32'h0);
        found = 1'b0;
        for (int n = 0; n < 6 && !found; n++) begin
            if (digit_sel != 4'b1110) found = 1'b1;
            else step();
        end
        check("mrst_adv", 32'(found), 32'h1);
        check("mrst_sel1", 32'(digit_sel), 32'h0000_000D);
        bus_read("mrst_value", B, 32'h0);
        bus_read("mrst_ctrl", B + 32'h4, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
